apb_master: RTL and testbench
=============================

# apb_master

APB-side engine of the AHB-to-APB bridge. Converts posted writes (from the write FIFO) and pending reads (from the AHB-side control FSM) into APB SETUP/ACCESS sequences. Splits an AHB transfer wider than the APB data bus into consecutive APB beats at incrementing addresses. For reads, it assembles the returned bytes onto AHB byte lanes and signals completion back to the AHB side.

## Interface
Parameters:
- AHB_AW, 32, address width (AHB and APB)
- AHB_DW, 32, AHB data width; only 32 supported
- APB_DW, 8, APB data width; legal values 8, 16, 32

Ports:
- HCLK  in  1  single clock for the block
- HRESETn  in  1  asynchronous, active-low reset
- i_start_read_transfer  in  1  read pending, from AHB-side FSM (level)
- i_HADDR  in  AHB_AW  sampled read address
- i_HSIZE  in  3  sampled read size
- i_fifo_empty  in  1  write FIFO empty
- i_fifo_addr  in  AHB_AW  FIFO head address
- i_fifo_size  in  3  FIFO head size
- i_fifo_data  in  AHB_DW  FIFO head data, AHB byte-lane positioned
- o_fifo_rd  out  1  pop FIFO head
- o_PADDR  out  AHB_AW  APB address
- o_PSEL  out  1  APB select
- o_PENABLE  out  1  APB enable
- o_PWRITE  out  1  APB direction
- o_PWDATA  out  APB_DW  APB write data
- i_PRDATA  in  APB_DW  APB read data
- i_PREADY  in  1  APB ready
- i_PSLVERR  in  1  APB error
- o_HRDATA  out  AHB_DW  assembled read data, to AHB side
- o_HREADY  out  1  one-cycle read-complete pulse, to AHB side
- o_HRESP  out  1  read error, valid with o_HREADY

## Operation
- States: IDLE, SETUP, ACCESS.
- APB strobes are Moore outputs decoded from the state register:
  - o_PSEL = SETUP|ACCESS
  - o_PENABLE = ACCESS
- Reset values: all outputs 0. State is IDLE and the beat counter is 0.
- IDLE, write request (!i_fifo_empty): writes have priority over reads.
  - Latch the FIFO head addr/size/data, set PWRITE=1, beat=0.
  - o_fifo_rd=1 for this cycle only, then go to SETUP.
- IDLE, read request (FIFO empty, i_start_read_transfer=1, o_HREADY=0):
  - Latch i_HADDR/i_HSIZE, set PWRITE=0, clear o_HRDATA to 0, go to SETUP.
  - The o_HREADY=0 gate blocks a restart in the completion-pulse cycle.
- o_fifo_rd is combinational. It is asserted only in IDLE and is 0 while HRESETn is low.
- Beat count: bytes = 1<<min(size,2); beats = max(1, bytes/(APB_DW/8)).
- Per-beat APB signals:
  - Beat k address: base + k*(APB_DW/8), modulo 2^AHB_AW (wraps at the top of the address space).
  - Byte lane for beat k: L = (base[1:0] + k*(APB_DW/8)) mod 4.
  - o_PWDATA = latched data[L*8 +: APB_DW].
  - Read beat writes i_PRDATA into o_HRDATA[L*8 +: APB_DW]; other lanes are unchanged.
- SETUP always goes to ACCESS after exactly one cycle.
- ACCESS:
  - PREADY=0: hold. PADDR, PWRITE, PWDATA, PSEL and PENABLE stay stable.
  - PREADY=1, not last beat: beat++, go to SETUP.
  - PREADY=1, last beat: go to IDLE. If the transfer is a read, o_HREADY=1 next cycle.
- o_HREADY and o_HRESP are registered and high for exactly one cycle.
- o_HRDATA holds its value after completion until the next read latch.
- Writes never assert o_HREADY; they are posted.
- Reset asserted mid-operation: outputs clear immediately and the state returns to IDLE. The in-flight entry is discarded (already popped), and no completion pulse follows.

## Timing
- Single-beat read, zero-wait APB:
  - Cycle 0: IDLE with request.
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS.
  - Cycle 3: o_HREADY.
- N beats with W total wait cycles: o_HREADY rises 2N+W+1 cycles after the request cycle.
- Back-to-back APB beats: no idle cycle between the ACCESS of beat k and the SETUP of beat k+1.
- Between transfers: at least one IDLE cycle.
- Read request held across a completion pulse: the next read starts the cycle after the pulse.

## Configuration
- APB_SLVERR_EN defined:
  - i_PSLVERR is sampled in ACCESS when PREADY=1.
  - On error, the remaining beats are skipped and the FSM goes to IDLE.
  - For a read, o_HRESP=1 together with the o_HREADY pulse.
  - For a write, the error is dropped.
- APB_SLVERR_EN undefined: i_PSLVERR is ignored, all beats are issued, and o_HRESP is tied 0.

## Structure
- Shared package ahb2apb_pkg holds:
  - state encoding localparams (IDLE/SETUP/ACCESS)
  - legal APB_DW values
  - beat-count function of (size, APB_DW)
- Optional sub-module apb_beat_ctrl: beat counter, last-beat flag, beat address and byte-lane index. The top level keeps the FSM, data latch and read assembly.

## Test plan
Tests use APB_DW=8 unless noted.
- Byte write: FIFO head addr 0x1003, size 0, data 0xAABBCCDD, PREADY=1 → one o_fifo_rd pulse; SETUP then ACCESS with PADDR 0x1003, PWDATA 0xAA, PWRITE=1; back to IDLE; no o_HREADY.
- Word read: i_HADDR 0x2000, size 2, PRDATA 0x11,0x22,0x33,0x44 → PADDR 0x2000..0x2003; o_HRDATA 0x44332211; o_HREADY pulse 9 cycles after the request.
- Halfword read at 0x2002, PRDATA 0x5A,0xA5 → o_HRDATA 0xA55A0000. With APB_DW=16: one beat at PADDR 0x2002.
- Wait states: PREADY low for 3 ACCESS cycles on beat 1 → all APB outputs stable, beat not advanced, completion delayed by exactly 3 cycles.
- Priority: read request and non-empty FIFO in the same cycle → write issued first; read begins only after the FIFO reports empty.
- Error and reset, with APB_SLVERR_EN, word read, PSLVERR on beat 1 → beats 2 and 3 not issued; o_HREADY=1 and o_HRESP=1. Without the macro → 4 beats and o_HRESP=0. HRESETn low during ACCESS → all outputs 0 asynchronously, IDLE after release, no pulse.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge: APB state encoding,
// APB data-width legality, beat-count and byte-lane helpers.
package ahb2apb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SETUP  = ST_SETUP,
        ACCESS = ST_ACCESS
    } apb_state_e;

    // APB data bus may be 8, 16 or 32 bits wide.
    function automatic bit apb_dw_legal(input int unsigned apb_dw);
        return (apb_dw == 32'd8) || (apb_dw == 32'd16) || (apb_dw == 32'd32);
    endfunction

    // Number of APB beats for an AHB size: max(1, bytes / apb_bytes).
    function automatic logic [2:0] apb_beat_count(input logic [2:0] size,
                                                  input int unsigned apb_dw);
        int unsigned bytes;
        int unsigned per_beat;
        int unsigned beats;
        bytes    = (size >= 3'd2) ? 32'd4 : ((size == 3'd1) ? 32'd2 : 32'd1);
        per_beat = apb_dw / 32'd8;
        beats    = (per_beat == 32'd0) ? 32'd1 : (bytes / per_beat);
        if (beats == 32'd0) beats = 32'd1;
        return 3'(beats);
    endfunction

    // Byte lane rounded down to an APB-bus boundary so a wide APB beat
    // never reads or writes past the top of the 32-bit AHB word.
    function automatic logic [1:0] lane_align(input logic [1:0] lane,
                                              input int unsigned apb_dw);
        logic [1:0] mask;
        mask = 2'(~((apb_dw / 32'd8) - 32'd1));
        return lane & mask;
    endfunction

endpackage

// File: rtl/apb_beat_ctrl.sv
// Beat sequencer for apb_master: beat counter, last-beat flag, address and
// byte lane of the current/next beat.
// Ports: HCLK, HRESETn; load/load_addr/load_size start a transfer;
// advance steps to the next beat; *_c outputs are combinational.
module apb_beat_ctrl
    import ahb2apb_pkg::*;
#(
    parameter int unsigned AHB_AW = 32,
    parameter int unsigned APB_DW = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              load,
    input  logic [AHB_AW-1:0] load_addr,
    input  logic [2:0]        load_size,
    input  logic              advance,
    output logic              last_beat_c,
    output logic [1:0]        cur_lane_c,
    output logic [AHB_AW-1:0] nxt_addr_c,
    output logic [1:0]        nxt_lane_c
);

    localparam int unsigned BPB = APB_DW / 8;

    logic [1:0]        beat_q;
    logic [1:0]        last_q;
    logic [AHB_AW-1:0] base_q;
    logic [2:0]        beat_nxt;

    // Beat counter and transfer base.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beat_q <= '0;
            last_q <= '0;
            base_q <= '0;
        end else if (load) begin
            beat_q <= '0;
            last_q <= 2'(apb_beat_count(load_size, APB_DW) - 3'd1);
            base_q <= load_addr;
        end else if (advance) begin
            beat_q <= beat_q + 2'd1;
        end
    end

    assign beat_nxt    = {1'b0, beat_q} + 3'd1;
    assign last_beat_c = (beat_q == last_q);
    // Address arithmetic wraps naturally at the top of the address space.
    assign nxt_addr_c  = base_q + (AHB_AW'(beat_nxt) * AHB_AW'(BPB));
    assign cur_lane_c  = lane_align(2'(base_q[1:0] + 2'(beat_q * BPB)), APB_DW);
    assign nxt_lane_c  = lane_align(2'(base_q[1:0] + 2'(beat_nxt * BPB)), APB_DW);

endmodule

// File: rtl/apb_master.sv
// APB-side engine of the AHB-to-APB bridge. Issues posted writes from the
// write FIFO and pending reads as APB SETUP/ACCESS sequences, splitting wide
// AHB transfers into APB beats and assembling read bytes onto AHB lanes.
// Ports: HCLK/HRESETn; read request (i_start_read_transfer, i_HADDR, i_HSIZE);
// write FIFO head (i_fifo_*) and pop (o_fifo_rd, combinational);
// APB master (o_P*, i_PRDATA, i_PREADY, i_PSLVERR);
// read completion (o_HRDATA, o_HREADY pulse, o_HRESP).
// Build option: APB_SLVERR_EN makes PSLVERR abort the transfer and, for
// reads, report o_HRESP; otherwise PSLVERR is ignored.
module apb_master
    import ahb2apb_pkg::*;
#(
    parameter int unsigned AHB_AW = 32,
    parameter int unsigned AHB_DW = 32,
    parameter int unsigned APB_DW = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              i_start_read_transfer,
    input  logic [AHB_AW-1:0] i_HADDR,
    input  logic [2:0]        i_HSIZE,
    input  logic              i_fifo_empty,
    input  logic [AHB_AW-1:0] i_fifo_addr,
    input  logic [2:0]        i_fifo_size,
    input  logic [AHB_DW-1:0] i_fifo_data,
    output logic              o_fifo_rd,
    output logic [AHB_AW-1:0] o_PADDR,
    output logic              o_PSEL,
    output logic              o_PENABLE,
    output logic              o_PWRITE,
    output logic [APB_DW-1:0] o_PWDATA,
    input  logic [APB_DW-1:0] i_PRDATA,
    input  logic              i_PREADY,
    input  logic              i_PSLVERR,
    output logic [AHB_DW-1:0] o_HRDATA,
    output logic              o_HREADY,
    output logic              o_HRESP
);

    if (AHB_DW != 32 || !apb_dw_legal(APB_DW)) begin : g_param_check
        $error("apb_master: AHB_DW must be 32 and APB_DW one of 8/16/32");
    end

    apb_state_e        state;
    logic [AHB_DW-1:0] data_q;
    logic              wr_req;
    logic              rd_req;
    logic              beat_adv;
    logic              slv_err;
    logic [AHB_AW-1:0] load_addr;
    logic [2:0]        load_size;
    logic              last_beat_c;
    logic [1:0]        cur_lane_c;
    logic [1:0]        nxt_lane_c;
    logic [AHB_AW-1:0] nxt_addr_c;

    // APB bytes selected from an AHB-lane-positioned word.
    function automatic logic [APB_DW-1:0] lane_slice(input logic [AHB_DW-1:0] d,
                                                     input logic [1:0] lane);
        return APB_DW'(d >> {lane, 3'b000});
    endfunction

    // Drop APB read bytes into their AHB lanes, keeping the other lanes.
    function automatic logic [AHB_DW-1:0] lane_merge(input logic [AHB_DW-1:0] cur,
                                                     input logic [APB_DW-1:0] rd,
                                                     input logic [1:0] lane);
        logic [AHB_DW-1:0] mask;
        mask = AHB_DW'({APB_DW{1'b1}}) << {lane, 3'b000};
        return (cur & ~mask) | (AHB_DW'(rd) << {lane, 3'b000});
    endfunction

`ifdef APB_SLVERR_EN
    assign slv_err = i_PSLVERR;
`else
    assign slv_err = 1'b0;
    logic unused_pslverr;
    assign unused_pslverr = i_PSLVERR;
`endif

    // Writes win over reads; the o_HREADY gate stops a read restarting in
    // its own completion-pulse cycle.
    assign wr_req    = (state == IDLE) && !i_fifo_empty;
    assign rd_req    = (state == IDLE) && i_fifo_empty && i_start_read_transfer && !o_HREADY;
    assign o_fifo_rd = wr_req && HRESETn;

    assign load_addr = wr_req ? i_fifo_addr : i_HADDR;
    assign load_size = wr_req ? i_fifo_size : i_HSIZE;
    assign beat_adv  = (state == ACCESS) && i_PREADY && !last_beat_c && !slv_err;

    assign o_PSEL    = (state != IDLE);
    assign o_PENABLE = (state == ACCESS);

    apb_beat_ctrl #(
        .AHB_AW (AHB_AW),
        .APB_DW (APB_DW)
    ) u_beat_ctrl (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .load        (wr_req || rd_req),
        .load_addr   (load_addr),
        .load_size   (load_size),
        .advance     (beat_adv),
        .last_beat_c (last_beat_c),
        .cur_lane_c  (cur_lane_c),
        .nxt_addr_c  (nxt_addr_c),
        .nxt_lane_c  (nxt_lane_c)
    );

    // APB sequencing FSM with registered address/data/completion outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= IDLE;
            data_q   <= '0;
            o_PADDR  <= '0;
            o_PWRITE <= 1'b0;
            o_PWDATA <= '0;
            o_HRDATA <= '0;
            o_HREADY <= 1'b0;
            o_HRESP  <= 1'b0;
        end else begin
            o_HREADY <= 1'b0;
            o_HRESP  <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        data_q   <= i_fifo_data;
                        o_PWRITE <= 1'b1;
                        o_PADDR  <= i_fifo_addr;
                        o_PWDATA <= lane_slice(i_fifo_data, lane_align(i_fifo_addr[1:0], APB_DW));
                        state    <= SETUP;
                    end else if (rd_req) begin
                        o_PWRITE <= 1'b0;
                        o_PADDR  <= i_HADDR;
                        o_HRDATA <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (i_PREADY) begin
                        if (!o_PWRITE) begin
                            o_HRDATA <= lane_merge(o_HRDATA, i_PRDATA, cur_lane_c);
                        end
                        if (last_beat_c || slv_err) begin
                            state    <= IDLE;
                            o_HREADY <= !o_PWRITE;
                            o_HRESP  <= !o_PWRITE && slv_err;
                        end else begin
                            state    <= SETUP;
                            o_PADDR  <= nxt_addr_c;
                            o_PWDATA <= lane_slice(data_q, nxt_lane_c);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          waits;
        logic        err;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic        resp;
        int          cyc;
        bit          chk_data;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } fifo_t;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        i_start_read_transfer;
    logic [31:0] i_HADDR;
    logic [2:0]  i_HSIZE;
    logic        i_fifo_empty;
    logic [31:0] i_fifo_addr;
    logic [2:0]  i_fifo_size;
    logic [31:0] i_fifo_data;
    logic        o_fifo_rd;
    logic [31:0] o_PADDR;
    logic        o_PSEL;
    logic        o_PENABLE;
    logic        o_PWRITE;
    logic [7:0]  o_PWDATA;
    logic [7:0]  i_PRDATA;
    logic        i_PREADY;
    logic        i_PSLVERR;
    logic [31:0] o_HRDATA;
    logic        o_HREADY;
    logic        o_HRESP;

    beat_t exp_q[$];
    rsp_t  rsp_q[$];
    fifo_t fq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_push  = 0;
    int n_pop   = 0;
    int req_cyc = 0;
    bit pop_pend = 1'b0;

    apb_master #(.AHB_AW(32), .AHB_DW(32), .APB_DW(8)) dut (
        .HCLK                  (HCLK),
        .HRESETn               (HRESETn),
        .i_start_read_transfer (i_start_read_transfer),
        .i_HADDR               (i_HADDR),
        .i_HSIZE               (i_HSIZE),
        .i_fifo_empty          (i_fifo_empty),
        .i_fifo_addr           (i_fifo_addr),
        .i_fifo_size           (i_fifo_size),
        .i_fifo_data           (i_fifo_data),
        .o_fifo_rd             (o_fifo_rd),
        .o_PADDR               (o_PADDR),
        .o_PSEL                (o_PSEL),
        .o_PENABLE             (o_PENABLE),
        .o_PWRITE              (o_PWRITE),
        .o_PWDATA              (o_PWDATA),
        .i_PRDATA              (i_PRDATA),
        .i_PREADY              (i_PREADY),
        .i_PSLVERR             (i_PSLVERR),
        .o_HRDATA              (o_HRDATA),
        .o_HREADY              (o_HREADY),
        .o_HRESP               (o_HRESP)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_beat(input logic [31:0] a, input logic w, input logic [7:0] wd,
                                      input logic [7:0] rd, input int waits, input logic err);
        beat_t b;
        b.addr = a; b.write = w; b.wdata = wd; b.rdata = rd; b.waits = waits; b.err = err;
        exp_q.push_back(b);
    endfunction

    function automatic void push_rsp(input logic [31:0] d, input logic r, input int c, input bit cd);
        rsp_t x;
        x.data = d; x.resp = r; x.cyc = c; x.chk_data = cd;
        rsp_q.push_back(x);
    endfunction

    function automatic void push_fifo(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        fifo_t f;
        f.addr = a; f.size = s; f.data = d;
        fq.push_back(f);
        n_push++;
    endfunction

    // Write FIFO model: pops on the DUT's o_fifo_rd, presents the head.
    always @(negedge HCLK) pop_pend = o_fifo_rd;
    always @(posedge HCLK) begin
        #1;
        if (pop_pend && fq.size() > 0) begin
            void'(fq.pop_front());
            n_pop++;
        end
        pop_pend = 1'b0;
        i_fifo_empty = (fq.size() == 0);
        if (fq.size() > 0) begin
            i_fifo_addr = fq[0].addr;
            i_fifo_size = fq[0].size;
            i_fifo_data = fq[0].data;
        end else begin
            i_fifo_addr = '0;
            i_fifo_size = '0;
            i_fifo_data = '0;
        end
    end

    // APB slave: wait states, read data and error taken from the expected beat.
    int   wait_left = 0;
    logic err_hold  = 1'b0;
    always @(posedge HCLK) begin
        #1;
        if (o_PSEL && !o_PENABLE) begin
            if (exp_q.size() > 0) begin
                wait_left = exp_q[0].waits;
                i_PRDATA  = exp_q[0].rdata;
                err_hold  = exp_q[0].err;
            end else begin
                wait_left = 0;
                i_PRDATA  = 8'h00;
                err_hold  = 1'b0;
            end
            i_PREADY  = 1'b0;
            i_PSLVERR = 1'b0;
        end else if (o_PSEL && o_PENABLE) begin
            if (wait_left > 0) begin
                wait_left--;
                i_PREADY  = 1'b0;
                i_PSLVERR = 1'b0;
            end else begin
                i_PREADY  = 1'b1;
                i_PSLVERR = err_hold;
            end
        end else begin
            i_PREADY  = 1'b0;
            i_PSLVERR = 1'b0;
        end
    end

    // Monitor: checks completed APB beats, wait-state stability and read completions.
    bit          hold_valid = 1'b0;
    logic [31:0] hold_addr;
    logic        hold_write;
    logic [7:0]  hold_wdata;
    always @(negedge HCLK) begin
        beat_t b;
        rsp_t  r;
        if (!HRESETn) begin
            hold_valid = 1'b0;
        end else begin
            if (o_PSEL && o_PENABLE) begin
                if (hold_valid) begin
                    chk("wait_paddr_stable", o_PADDR, hold_addr);
                    chk("wait_pwrite_stable", 32'(o_PWRITE), 32'(hold_write));
                    chk("wait_pwdata_stable", 32'(o_PWDATA), 32'(hold_wdata));
                end
                if (i_PREADY) begin
                    hold_valid = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_apb_beat", o_PADDR, 32'hFFFF_FFFF ^ o_PADDR);
                    end else begin
                        b = exp_q.pop_front();
                        chk("paddr", o_PADDR, b.addr);
                        chk("pwrite", 32'(o_PWRITE), 32'(b.write));
                        if (b.write) chk("pwdata", 32'(o_PWDATA), 32'(b.wdata));
                    end
                end else begin
                    hold_valid = 1'b1;
                    hold_addr  = o_PADDR;
                    hold_write = o_PWRITE;
                    hold_wdata = o_PWDATA;
                end
            end else begin
                hold_valid = 1'b0;
            end
            if (o_HREADY) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_hready", 32'(o_HREADY), 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    if (r.chk_data) chk("hrdata", o_HRDATA, r.data);
                    chk("hresp", 32'(o_HRESP), 32'(r.resp));
                    if (r.cyc >= 0) chk("hready_latency", 32'(cyc), 32'(r.cyc));
                end
            end
        end
    end

    task automatic wait_idle();
        int i;
        i = 0;
        do begin
            @(posedge HCLK);
            #1;
            i++;
        end while ((o_PSEL || o_HREADY) && i < 300);
        if (i >= 300) chk("wait_idle_timeout", 32'(o_PSEL), 32'd0);
    endtask

    task automatic start_read(input logic [31:0] a, input logic [2:0] s);
        wait_idle();
        i_HADDR = a;
        i_HSIZE = s;
        i_start_read_transfer = 1'b1;
        req_cyc = cyc;
    endtask

    task automatic wait_hready(input string name);
        int i;
        i = 0;
        do begin
            @(negedge HCLK);
            i++;
        end while (!o_HREADY && i < 200);
        if (i >= 200) chk({name, "_hready_timeout"}, 32'(o_HREADY), 32'd1);
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || rsp_q.size() != 0 || fq.size() != 0 || o_PSEL) && i < 300) begin
            @(negedge HCLK);
            i++;
        end
        if (i >= 300) chk({name, "_drain_timeout"}, 32'(exp_q.size() + rsp_q.size()), 32'd0);
        repeat (2) @(negedge HCLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0;
        i_start_read_transfer = 1'b0;
        i_HADDR = '0; i_HSIZE = '0;
        i_fifo_empty = 1'b1; i_fifo_addr = '0; i_fifo_size = '0; i_fifo_data = '0;
        i_PRDATA = '0; i_PREADY = 1'b0; i_PSLVERR = 1'b0;

        repeat (3) @(negedge HCLK);
        chk("rst_psel", 32'(o_PSEL), 32'd0);
        chk("rst_penable", 32'(o_PENABLE), 32'd0);
        chk("rst_pwrite", 32'(o_PWRITE), 32'd0);
        chk("rst_paddr", o_PADDR, 32'd0);
        chk("rst_pwdata", 32'(o_PWDATA), 32'd0);
        chk("rst_hrdata", o_HRDATA, 32'd0);
        chk("rst_hready", 32'(o_HREADY), 32'd0);
        chk("rst_hresp", 32'(o_HRESP), 32'd0);
        chk("rst_fifo_rd", 32'(o_fifo_rd), 32'd0);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        // Byte write at lane 3.
        wait_idle();
        push_fifo(32'h0000_1003, 3'd0, 32'hAABB_CCDD);
        push_beat(32'h0000_1003, 1'b1, 8'hAA, 8'h00, 0, 1'b0);
        drain("byte_write");

        // Halfword write, two beats.
        push_fifo(32'h0000_1000, 3'd1, 32'hAABB_CCDD);
        push_beat(32'h0000_1000, 1'b1, 8'hDD, 8'h00, 0, 1'b0);
        push_beat(32'h0000_1001, 1'b1, 8'hCC, 8'h00, 0, 1'b0);
        drain("half_write");

        // Size above word is treated as a word.
        push_fifo(32'h0000_4000, 3'd3, 32'h0102_0304);
        push_beat(32'h0000_4000, 1'b1, 8'h04, 8'h00, 0, 1'b0);
        push_beat(32'h0000_4001, 1'b1, 8'h03, 8'h00, 0, 1'b0);
        push_beat(32'h0000_4002, 1'b1, 8'h02, 8'h00, 0, 1'b0);
        push_beat(32'h0000_4003, 1'b1, 8'h01, 8'h00, 0, 1'b0);
        drain("size3_write");

        // Word read, zero wait: pulse 9 cycles after request.
        start_read(32'h0000_2000, 3'd2);
        push_beat(32'h0000_2000, 1'b0, 8'h00, 8'h11, 0, 1'b0);
        push_beat(32'h0000_2001, 1'b0, 8'h00, 8'h22, 0, 1'b0);
        push_beat(32'h0000_2002, 1'b0, 8'h00, 8'h33, 0, 1'b0);
        push_beat(32'h0000_2003, 1'b0, 8'h00, 8'h44, 0, 1'b0);
        push_rsp(32'h4433_2211, 1'b0, req_cyc + 9, 1'b1);
        wait_hready("word_read");
        i_start_read_transfer = 1'b0;
        drain("word_read");

        // Halfword read at upper lanes.
        start_read(32'h0000_2002, 3'd1);
        push_beat(32'h0000_2002, 1'b0, 8'h00, 8'h5A, 0, 1'b0);
        push_beat(32'h0000_2003, 1'b0, 8'h00, 8'hA5, 0, 1'b0);
        push_rsp(32'hA55A_0000, 1'b0, req_cyc + 5, 1'b1);
        wait_hready("half_read");
        i_start_read_transfer = 1'b0;
        drain("half_read");

        // Three wait states on beat 1.
        start_read(32'h0000_2000, 3'd2);
        push_beat(32'h0000_2000, 1'b0, 8'h00, 8'h01, 0, 1'b0);
        push_beat(32'h0000_2001, 1'b0, 8'h00, 8'h02, 3, 1'b0);
        push_beat(32'h0000_2002, 1'b0, 8'h00, 8'h03, 0, 1'b0);
        push_beat(32'h0000_2003, 1'b0, 8'h00, 8'h04, 0, 1'b0);
        push_rsp(32'h0403_0201, 1'b0, req_cyc + 12, 1'b1);
        wait_hready("wait_read");
        i_start_read_transfer = 1'b0;
        drain("wait_read");

        // Address wrap at the top of the address space.
        start_read(32'hFFFF_FFFF, 3'd1);
        push_beat(32'hFFFF_FFFF, 1'b0, 8'h00, 8'h77, 0, 1'b0);
        push_beat(32'h0000_0000, 1'b0, 8'h00, 8'h88, 0, 1'b0);
        push_rsp(32'h7700_0088, 1'b0, req_cyc + 5, 1'b1);
        wait_hready("wrap_read");
        i_start_read_transfer = 1'b0;
        drain("wrap_read");

        // Request held across the pulse: second read starts the cycle after it.
        start_read(32'h0000_3001, 3'd0);
        push_beat(32'h0000_3001, 1'b0, 8'h00, 8'h5C, 0, 1'b0);
        push_rsp(32'h0000_5C00, 1'b0, req_cyc + 3, 1'b1);
        push_beat(32'h0000_3007, 1'b0, 8'h00, 8'hE7, 0, 1'b0);
        push_rsp(32'hE700_0000, 1'b0, req_cyc + 7, 1'b1);
        wait_hready("b2b_first");
        i_HADDR = 32'h0000_3007;
        wait_hready("b2b_second");
        i_start_read_transfer = 1'b0;
        drain("b2b_read");

        // Write and read requested together: write goes first.
        wait_idle();
        push_fifo(32'h0000_5000, 3'd0, 32'h0000_00EE);
        push_beat(32'h0000_5000, 1'b1, 8'hEE, 8'h00, 0, 1'b0);
        push_beat(32'h0000_6002, 1'b0, 8'h00, 8'h3C, 0, 1'b0);
        push_rsp(32'h003C_0000, 1'b0, -1, 1'b1);
        @(posedge HCLK);
        #2;
        i_HADDR = 32'h0000_6002;
        i_HSIZE = 3'd0;
        i_start_read_transfer = 1'b1;
        wait_hready("priority");
        i_start_read_transfer = 1'b0;
        drain("priority");

        // Slave error on beat 1 of a word read.
        start_read(32'h0000_7000, 3'd2);
`ifdef APB_SLVERR_EN
        push_beat(32'h0000_7000, 1'b0, 8'h00, 8'h11, 0, 1'b0);
        push_beat(32'h0000_7001, 1'b0, 8'h00, 8'h22, 0, 1'b1);
        push_rsp(32'h0, 1'b1, req_cyc + 5, 1'b0);
`else
        push_beat(32'h0000_7000, 1'b0, 8'h00, 8'h11, 0, 1'b0);
        push_beat(32'h0000_7001, 1'b0, 8'h00, 8'h22, 0, 1'b1);
        push_beat(32'h0000_7002, 1'b0, 8'h00, 8'h33, 0, 1'b0);
        push_beat(32'h0000_7003, 1'b0, 8'h00, 8'h44, 0, 1'b0);
        push_rsp(32'h4433_2211, 1'b0, req_cyc + 9, 1'b1);
`endif
        wait_hready("err_read");
        i_start_read_transfer = 1'b0;
        drain("err_read");

        // Slave error on beat 1 of a word write: never reported.
        wait_idle();
        push_fifo(32'h0000_7100, 3'd2, 32'hDEAD_BEEF);
        push_beat(32'h0000_7100, 1'b1, 8'hEF, 8'h00, 0, 1'b0);
        push_beat(32'h0000_7101, 1'b1, 8'hBE, 8'h00, 0, 1'b1);
`ifndef APB_SLVERR_EN
        push_beat(32'h0000_7102, 1'b1, 8'hAD, 8'h00, 0, 1'b0);
        push_beat(32'h0000_7103, 1'b1, 8'hDE, 8'h00, 0, 1'b0);
`endif
        drain("err_write");

        // Reset asserted during a held ACCESS.
        start_read(32'h0000_7200, 3'd2);
        push_beat(32'h0000_7200, 1'b0, 8'h00, 8'h99, 20, 1'b0);
        push_rsp(32'h0000_0099, 1'b0, -1, 1'b1);
        begin
            int i;
            i = 0;
            do begin
                @(negedge HCLK);
                i++;
            end while (!o_PENABLE && i < 50);
            if (i >= 50) chk("reset_access_timeout", 32'(o_PENABLE), 32'd1);
        end
        @(negedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_psel", 32'(o_PSEL), 32'd0);
        chk("arst_penable", 32'(o_PENABLE), 32'd0);
        chk("arst_pwrite", 32'(o_PWRITE), 32'd0);
        chk("arst_paddr", o_PADDR, 32'd0);
        chk("arst_hready", 32'(o_HREADY), 32'd0);
        chk("arst_hrdata", o_HRDATA, 32'd0);
        chk("arst_fifo_rd", 32'(o_fifo_rd), 32'd0);
        exp_q.delete();
        rsp_q.delete();
        i_start_read_transfer = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (10) @(negedge HCLK);
        chk("post_reset_idle", 32'(o_PSEL), 32'd0);
        chk("post_reset_hrdata", o_HRDATA, 32'd0);

        chk("fifo_pop_count", 32'(n_pop), 32'(n_push));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
